// File: rtl/vga_draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_arbiter_if
// Purpose  : Bundle for the drawing clients' rectangle requests and for the
//            pixel write port that feeds the 160x120 vga_adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_draw_arbiter_if #(
   parameter int NUM_REQ = 3
);
   // client side: one rectangle request per client, packed by client index
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_x;
   logic [7*NUM_REQ-1:0] req_y;
   logic [8*NUM_REQ-1:0] req_w;
   logic [7*NUM_REQ-1:0] req_h;
   logic [6*NUM_REQ-1:0] req_colour;
   logic [NUM_REQ-1:0]   ack;
   logic [NUM_REQ-1:0]   done;
   logic                 busy;

   // framebuffer side
   logic [7:0]           X;
   logic [6:0]           Y;
   logic [5:0]           colour;
   logic                 writeEn;

   modport master (
      output req, req_x, req_y, req_w, req_h, req_colour,
      input  ack, done, busy, X, Y, colour, writeEn
   );

   modport slave (
      input  req, req_x, req_y, req_w, req_h, req_colour,
      output ack, done, busy, X, Y, colour, writeEn
   );
endinterface
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_arbiter
// Purpose  : Round-robin arbiter that shares the vga_adapter write port
//            between NUM_REQ clients; each granted client gets one filled
//            rectangle swept one pixel per clock, with off-screen clipping.
// Revision : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic              clk,
   input  logic              reset_n,
   vga_draw_arbiter_if.slave bus
);
   localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;

   logic [c_PTR_W-1:0]   r_ptr;
   logic [c_PTR_W-1:0]   r_owner;
   logic [c_PTR_W-1:0]   w_cand;
   logic [c_PTR_W-1:0]   w_win_idx;
   logic                 w_win_valid;

   // latched job
   logic [7:0]           r_x0;
   logic [6:0]           r_y0;
   logic [7:0]           r_w;
   logic [6:0]           r_h;
   logic [5:0]           r_colour;
   logic                 r_empty;
   logic [7:0]           r_cx;
   logic [6:0]           r_cy;

   // registered outputs
   logic [NUM_REQ-1:0]   r_ack;
   logic [NUM_REQ-1:0]   r_done;
   logic [7:0]           r_X;
   logic [6:0]           r_Y;
   logic [5:0]           r_pix_colour;
   logic                 r_we;

   // geometry of the current arbitration winner
   logic [7:0]           w_req_x;
   logic [6:0]           w_req_y;
   logic [7:0]           w_req_w;
   logic [6:0]           w_req_h;
   logic [5:0]           w_req_colour;
   logic                 w_req_empty;

   // sweep arithmetic; sums are one bit wider so wrap-around is still clipped
   logic [8:0]           w_sum_x;
   logic [7:0]           w_sum_y;
   logic                 w_last_col;
   logic                 w_last_row;

   // Round-robin search beginning one past the last served client
   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      w_cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_cand = c_PTR_W'((int'(r_ptr) + i) % NUM_REQ);
         if (!w_win_valid && bus.req[w_cand]) begin
            w_win_valid = 1'b1;
            w_win_idx   = w_cand;
         end
      end
   end

   // Select the winning client's rectangle from the packed request buses
   always_comb begin
      w_req_x      = '0;
      w_req_y      = '0;
      w_req_w      = '0;
      w_req_h      = '0;
      w_req_colour = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win_idx == c_PTR_W'(i)) begin
            w_req_x      = bus.req_x[8*i +: 8];
            w_req_y      = bus.req_y[7*i +: 7];
            w_req_w      = bus.req_w[8*i +: 8];
            w_req_h      = bus.req_h[7*i +: 7];
            w_req_colour = bus.req_colour[6*i +: 6];
         end
      end
   end

   assign w_req_empty = (w_req_w == 8'd0) || (w_req_h == 7'd0);
   assign w_sum_x     = {1'b0, r_x0} + {1'b0, r_cx};
   assign w_sum_y     = {1'b0, r_y0} + {1'b0, r_cy};
   assign w_last_col  = (r_cx == r_w - 8'd1);
   assign w_last_row  = (r_cy == r_h - 7'd1);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode: empty jobs skip the sweep entirely
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_win_valid) begin
               w_next_state = w_req_empty ? S_DONE : S_DRAW;
            end
         end
         S_DRAW: begin
            if (w_last_col && w_last_row) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Job latch, raster counters, pixel pipeline stage and handshake pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr        <= c_PTR_W'(NUM_REQ - 1);
         r_owner      <= '0;
         r_x0         <= '0;
         r_y0         <= '0;
         r_w          <= '0;
         r_h          <= '0;
         r_colour     <= '0;
         r_empty      <= 1'b0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_ack        <= '0;
         r_done       <= '0;
         r_X          <= '0;
         r_Y          <= '0;
         r_pix_colour <= '0;
         r_we         <= 1'b0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         r_we   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_valid) begin
                  r_owner          <= w_win_idx;
                  r_x0             <= w_req_x;
                  r_y0             <= w_req_y;
                  r_w              <= w_req_w;
                  r_h              <= w_req_h;
                  r_colour         <= w_req_colour;
                  r_empty          <= w_req_empty;
                  r_cx             <= '0;
                  r_cy             <= '0;
                  r_ack[w_win_idx] <= 1'b1;
               end
            end
            S_DRAW: begin
               // off-screen pixels still take their cycle, just without a plot
               r_X          <= w_sum_x[7:0];
               r_Y          <= w_sum_y[6:0];
               r_pix_colour <= r_colour;
               r_we         <= (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));
               if (w_last_col) begin
                  r_cx <= '0;
                  r_cy <= r_cy + 7'd1;
                  // done lines up with the last pixel's plot cycle
                  if (w_last_row) begin
                     r_done[r_owner] <= 1'b1;
                  end
               end else begin
                  r_cx <= r_cx + 8'd1;
               end
            end
            S_DONE: begin
               r_ptr <= r_owner;
               // an empty job never swept, so its done comes one cycle after ack
               if (r_empty) begin
                  r_done[r_owner] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ack     = r_ack;
   assign bus.done    = r_done;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.X       = r_X;
   assign bus.Y       = r_Y;
   assign bus.colour  = r_pix_colour;
   assign bus.writeEn = r_we;
endmodule
`default_nettype wire
